fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues instruction reads to the icache.
- Buffers a returned instruction while decode is stalled.
- Applies branch/jump redirects from later stages, and drives the IF/ID register's instruction, imemaddr, next_imemaddr, enable and flush inputs.

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's icache, hazard/redirect and IF/ID signals.
//   master : the fetch unit (drives imemREN/imemaddr and the IF/ID controls)
//   slave  : the environment (icache, hazard unit, later stages, IF/ID reg)
interface fetch_unit_if;
    // icache side
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    // hazard / redirect / halt from later stages
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt;
    // IF/ID register controls and payload
    logic [31:0] instruction;
    logic [31:0] next_imemaddr;
    logic        enable_IF_ID;
    logic        flush_IF_ID;

    modport master (
        input  ihit, iload, stall, redirect_valid, redirect_addr, halt,
        output imemREN, imemaddr, instruction, next_imemaddr,
               enable_IF_ID, flush_IF_ID
    );

    modport slave (
        output ihit, iload, stall, redirect_valid, redirect_addr, halt,
        input  imemREN, imemaddr, instruction, next_imemaddr,
               enable_IF_ID, flush_IF_ID
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads, buffers a
// returned word while decode is stalled, applies downstream redirects and
// drives the IF/ID register's load/flush controls.
// Ports:
//   CLK  - clock, all state changes on the rising edge
//   RST  - synchronous active-high reset
//   bus  - fetch_unit_if.master (icache, hazard, redirect, halt, IF/ID)
// The IF/ID controls depend on this cycle's ihit/stall/redirect, so they are
// decoded combinationally from the registered state and the inputs.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master bus
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_STEP  = 4;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   hold_buf_q, hold_buf_d;

    logic              imem_ren_c;
    logic              enable_c;
    logic              flush_c;
    logic [XLEN-1:0]   instruction_c;
    logic [XLEN-1:0]   pc_plus4_c;
    logic [XLEN-1:0]   redirect_pc_c;

    // Sequential PC increment wraps naturally at 2^32.
    assign pc_plus4_c    = pc_q + XLEN'(PC_STEP);
    // Redirect targets are word aligned; low two bits are dropped.
    assign redirect_pc_c = bus.redirect_addr & ~XLEN'(3);

    // Next-state and output decode; priority halt > redirect > stall > normal.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_buf_d    = hold_buf_q;
        imem_ren_c    = 1'b0;
        enable_c      = 1'b0;
        flush_c       = 1'b0;
        instruction_c = '0;

        unique case (state_q)
            S_FETCH: begin
                imem_ren_c    = 1'b1;
                instruction_c = bus.iload;
                if (bus.halt) begin
                    state_d = S_HALTED;
                end else if (bus.redirect_valid) begin
                    // Any word returned this cycle belongs to the squashed path.
                    pc_d    = redirect_pc_c;
                    flush_c = 1'b1;
                end else if (bus.ihit) begin
                    if (bus.stall) begin
                        // Park the word; the icache request is not repeated.
                        hold_buf_d = bus.iload;
                        state_d    = S_HOLD;
                    end else begin
                        enable_c = 1'b1;
                        pc_d     = pc_plus4_c;
                    end
                end
            end

            S_HOLD: begin
                // pc has not advanced, so it still names the buffered word.
                instruction_c = hold_buf_q;
                if (bus.halt) begin
                    state_d = S_HALTED;
                end else if (bus.redirect_valid) begin
                    pc_d    = redirect_pc_c;
                    flush_c = 1'b1;
                    state_d = S_FETCH;
                end else if (!bus.stall) begin
                    enable_c = 1'b1;
                    pc_d     = pc_plus4_c;
                    state_d  = S_FETCH;
                end
            end

            S_HALTED: begin
                // Frozen until reset; redirect and stall have no effect.
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every request and IF/ID control in the same cycle.
        if (RST) begin
            imem_ren_c    = 1'b0;
            enable_c      = 1'b0;
            flush_c       = 1'b0;
            instruction_c = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_INIT;
            hold_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_buf_q <= hold_buf_d;
        end
    end

    assign bus.imemREN       = imem_ren_c;
    assign bus.imemaddr      = pc_q;
    assign bus.instruction   = instruction_c;
    assign bus.next_imemaddr = pc_plus4_c;
    assign bus.enable_IF_ID  = enable_c;
    assign bus.flush_IF_ID   = flush_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic CLK;
    logic RST;
    fetch_unit_if bus();

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Behavioural model: where fetch is, whether a word is parked, halted.
    logic [31:0] m_pc;
    logic        m_held;
    logic [31:0] m_buf;
    logic        m_halted;
    logic        m_init   = 1'b0;
    logic        rnd_phase = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synthetic instruction memory contents, a pure function of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge CLK) begin
        logic        e_ren;
        logic        e_en;
        logic        e_fl;
        logic [31:0] e_ins;
        logic        chk_ins;
        if (RST) begin
            chk("rst_ren",   32'(bus.imemREN),     32'd0);
            chk("rst_en",    32'(bus.enable_IF_ID), 32'd0);
            chk("rst_flush", 32'(bus.flush_IF_ID),  32'd0);
            chk("rst_instr", bus.instruction,       32'd0);
            m_pc     = PC_INIT;
            m_held   = 1'b0;
            m_buf    = 32'd0;
            m_halted = 1'b0;
            m_init   = 1'b1;
        end else if (m_init) begin
            chk("m_addr", bus.imemaddr,      m_pc);
            chk("m_next", bus.next_imemaddr, m_pc + 32'd4);
            e_en    = 1'b0;
            e_fl    = 1'b0;
            e_ren   = !m_halted && !m_held;
            e_ins   = m_held ? m_buf : bus.iload;
            chk_ins = !m_halted;
            if (!m_halted) begin
                if (bus.halt) begin
                    m_halted = 1'b1;
                end else if (bus.redirect_valid) begin
                    e_fl   = 1'b1;
                    m_pc   = bus.redirect_addr & ~32'd3;
                    m_held = 1'b0;
                end else if ((m_held || bus.ihit) && !bus.stall) begin
                    e_en = 1'b1;
                    if (rnd_phase)
                        chk("m_deliv_word", bus.instruction, imem_word(m_pc));
                    m_pc   = m_pc + 32'd4;
                    m_held = 1'b0;
                end else if (bus.ihit && !m_held) begin
                    m_held = 1'b1;
                    m_buf  = bus.iload;
                end
            end
            chk("m_ren",   32'(bus.imemREN),      32'(e_ren));
            chk("m_en",    32'(bus.enable_IF_ID), 32'(e_en));
            chk("m_flush", 32'(bus.flush_IF_ID),  32'(e_fl));
            if (chk_ins)
                chk("m_instr", bus.instruction, e_ins);
        end
    end

    // One cycle of stimulus; returns shortly before the sampling edge.
    task automatic step(input logic rst, input logic ih, input logic [31:0] ld,
                        input logic st, input logic rv, input logic [31:0] ra,
                        input logic hl);
        @(posedge CLK);
        #1;
        RST                = rst;
        bus.ihit           = ih;
        bus.iload          = ld;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.halt           = hl;
        #3;
    endtask

    initial begin
        RST = 1'b1;
        bus.ihit = 1'b0; bus.iload = '0; bus.stall = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.halt = 1'b0;

        // Reset
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 32'd0, 0, 0, 32'd0, 0);
            chk("lit_rst_ren", 32'(bus.imemREN),     32'd0);
            chk("lit_rst_en",  32'(bus.enable_IF_ID), 32'd0);
        end

        // Streaming fetch with a hit every cycle
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h1111_0000 + 32'(i), 0, 0, 32'd0, 0);
            chk("lit_stream_addr", bus.imemaddr,      32'(4 * i));
            chk("lit_stream_next", bus.next_imemaddr, 32'(4 * i + 4));
            chk("lit_stream_en",   32'(bus.enable_IF_ID), 32'd1);
        end

        // icache miss: request held stable
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'hDEAD_BEEF, 0, 0, 32'd0, 0);
            chk("lit_miss_ren",  32'(bus.imemREN),      32'd1);
            chk("lit_miss_addr", bus.imemaddr,          32'h10);
            chk("lit_miss_en",   32'(bus.enable_IF_ID), 32'd0);
        end
        step(0, 1, 32'h8C22_0004, 0, 0, 32'd0, 0);
        chk("lit_miss_hit_en",    32'(bus.enable_IF_ID), 32'd1);
        chk("lit_miss_hit_instr", bus.instruction,       32'h8C22_0004);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h2222_0000 + 32'(i), 0, 0, 32'd0, 0);
            chk("lit_adv_addr", bus.imemaddr, 32'h14 + 32'(4 * i));
        end

        // Stall with a returned word: hold and deliver once
        step(0, 1, 32'h0022_1820, 1, 0, 32'd0, 0);
        chk("lit_hold_in_addr", bus.imemaddr,          32'h20);
        chk("lit_hold_in_en",   32'(bus.enable_IF_ID), 32'd0);
        step(0, 0, 32'hFFFF_0000, 1, 0, 32'd0, 0);
        chk("lit_hold_ren",   32'(bus.imemREN),      32'd0);
        chk("lit_hold_instr", bus.instruction,       32'h0022_1820);
        chk("lit_hold_en",    32'(bus.enable_IF_ID), 32'd0);
        step(0, 0, 32'hFFFF_0001, 0, 0, 32'd0, 0);
        chk("lit_hold_rel_en",    32'(bus.enable_IF_ID), 32'd1);
        chk("lit_hold_rel_instr", bus.instruction,       32'h0022_1820);
        chk("lit_hold_rel_addr",  bus.imemaddr,          32'h20);
        step(0, 0, 32'd0, 0, 0, 32'd0, 0);
        chk("lit_hold_after_addr", bus.imemaddr,     32'h24);
        chk("lit_hold_after_ren",  32'(bus.imemREN), 32'd1);

        // Redirect beats a simultaneous hit + stall
        step(0, 1, 32'h1234_5678, 1, 1, 32'h0000_0103, 0);
        chk("lit_redir_flush", 32'(bus.flush_IF_ID),  32'd1);
        chk("lit_redir_en",    32'(bus.enable_IF_ID), 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0, 0);
        chk("lit_redir_addr",  bus.imemaddr,         32'h100);
        chk("lit_redir_flush0", 32'(bus.flush_IF_ID), 32'd0);

        // Redirect while holding
        step(0, 1, 32'hAAAA_0001, 1, 0, 32'd0, 0);
        step(0, 0, 32'd0, 1, 1, 32'h0000_0200, 0);
        chk("lit_hredir_flush", 32'(bus.flush_IF_ID),  32'd1);
        chk("lit_hredir_en",    32'(bus.enable_IF_ID), 32'd0);
        chk("lit_hredir_ren",   32'(bus.imemREN),      32'd0);
        step(0, 0, 32'h7777_7777, 0, 0, 32'd0, 0);
        chk("lit_hredir_addr", bus.imemaddr,     32'h200);
        chk("lit_hredir_ren1", 32'(bus.imemREN), 32'd1);

        // Halt beats a concurrent redirect, then stays frozen
        step(0, 1, 32'h3333_3333, 0, 1, 32'h0000_0300, 1);
        chk("lit_halt_flush", 32'(bus.flush_IF_ID),  32'd0);
        chk("lit_halt_en",    32'(bus.enable_IF_ID), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h4444_4444, 1, 1, 32'h0000_0400, 0);
            chk("lit_halted_ren",   32'(bus.imemREN),     32'd0);
            chk("lit_halted_flush", 32'(bus.flush_IF_ID), 32'd0);
            chk("lit_halted_addr",  bus.imemaddr,         32'h200);
        end

        // Reset out of HALTED, then PC wrap at the top of the address space
        step(1, 0, 32'd0, 0, 0, 32'd0, 0);
        chk("lit_rst2_ren", 32'(bus.imemREN), 32'd0);
        step(0, 0, 32'd0, 0, 0, 32'd0, 0);
        chk("lit_rst2_addr", bus.imemaddr,     PC_INIT);
        chk("lit_rst2_ren1", 32'(bus.imemREN), 32'd1);
        step(0, 0, 32'd0, 0, 1, 32'hFFFF_FFFF, 0);
        chk("lit_wrap_flush", 32'(bus.flush_IF_ID), 32'd1);
        step(0, 1, 32'h0BAD_F00D, 0, 0, 32'd0, 0);
        chk("lit_wrap_addr", bus.imemaddr,          32'hFFFF_FFFC);
        chk("lit_wrap_next", bus.next_imemaddr,     32'h0);
        chk("lit_wrap_en",   32'(bus.enable_IF_ID), 32'd1);
        step(0, 0, 32'd0, 0, 0, 32'd0, 0);
        chk("lit_wrap_pc0", bus.imemaddr, 32'h0);

        // Randomized traffic; iload returns the memory word at the PC
        rnd_phase = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            RST                = ($urandom_range(0, 99) < 2);
            bus.ihit           = ($urandom_range(0, 99) < 60);
            bus.stall          = ($urandom_range(0, 99) < 30);
            bus.redirect_valid = ($urandom_range(0, 99) < 8);
            bus.redirect_addr  = $urandom;
            bus.halt           = ($urandom_range(0, 199) < 1);
            bus.iload          = bus.ihit ? imem_word(bus.imemaddr) : $urandom;
        end

        @(posedge CLK);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
